// File: rtl/ram_arbiter_if.sv
// Bus bundle for the RAM arbiter: the three requester channels, the shared
// read-data/status returns and the single-port RAM strobe interface.
interface ram_arbiter_if;
    // loader (write-only) channel
    logic        ld_req;
    logic [24:0] ld_addr;
    logic [7:0]  ld_din;
    logic        ld_ack;
    // floppy buffer (read-only) channel
    logic        fd_req;
    logic [24:0] fd_addr;
    logic        fd_ack;
    // CPU channel
    logic        cpu_req;
    logic        cpu_we;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic        cpu_wait;
    // shared returns
    logic [7:0]  rd_data;
    logic        busy;
    logic        timeout_err;
    // RAM side
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic        mem_we;
    logic        mem_ready;
    logic [7:0]  mem_dout;

    // arbiter view
    modport slave (
        input  ld_req, ld_addr, ld_din, fd_req, fd_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  mem_ready, mem_dout,
        output ld_ack, fd_ack, cpu_ack, cpu_wait, rd_data, busy, timeout_err,
        output mem_addr, mem_din, mem_rd, mem_we
    );

    // requester / RAM-model view
    modport master (
        output ld_req, ld_addr, ld_din, fd_req, fd_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output mem_ready, mem_dout,
        input  ld_ack, fd_ack, cpu_ack, cpu_wait, rd_data, busy, timeout_err,
        input  mem_addr, mem_din, mem_rd, mem_we
    );
endinterface

// File: rtl/ram_arbiter.sv
// Three-way arbiter in front of a single-port byte RAM. Loader writes beat
// floppy reads beat CPU accesses, except that the CPU is forced through once
// it has been passed over STARVE_MAX times in a row. Each access runs
// IDLE -> ISSUE -> WAIT -> DONE; a RAM that never answers is cut off after
// TIMEOUT wait cycles and the access completes with 0xFF read data.
module ram_arbiter #(
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk_sys,
    input  logic         reset,
    ram_arbiter_if.slave bus
);
    localparam int            SW         = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_LD, OWN_FD, OWN_CPU} owner_t;

    state_t        r_state;
    owner_t        r_owner;
    logic          r_we;
    logic [SW-1:0] r_starve;
    logic [7:0]    r_tmo;
    logic          r_ld_ack;
    logic          r_fd_ack;
    logic          r_cpu_ack;
    logic          r_mem_rd;
    logic          r_mem_we;
    logic [24:0]   r_mem_addr;
    logic [7:0]    r_mem_din;
    logic [7:0]    r_rd_data;
    logic          r_busy;
    logic          r_timeout_err;

    logic          w_any_req;
    logic          w_cpu_first;
    logic          w_gnt_ld;
    logic          w_gnt_fd;
    logic          w_gnt_cpu;

    assign w_any_req   = bus.ld_req || bus.fd_req || bus.cpu_req;
    assign w_cpu_first = bus.cpu_req && (r_starve == STARVE_LIM);

    // Winner of the current IDLE cycle; starvation override beats fixed priority
    always_comb begin
        w_gnt_ld  = 1'b0;
        w_gnt_fd  = 1'b0;
        w_gnt_cpu = 1'b0;
        if (w_cpu_first) begin
            w_gnt_cpu = 1'b1;
        end else if (bus.ld_req) begin
            w_gnt_ld = 1'b1;
        end else if (bus.fd_req) begin
            w_gnt_fd = 1'b1;
        end else if (bus.cpu_req) begin
            w_gnt_cpu = 1'b1;
        end
    end

    // Transaction FSM with all registered outputs and the starvation counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_owner       <= OWN_LD;
            r_we          <= 1'b0;
            r_starve      <= '0;
            r_tmo         <= 8'd0;
            r_ld_ack      <= 1'b0;
            r_fd_ack      <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 25'd0;
            r_mem_din     <= 8'd0;
            r_rd_data     <= 8'hFF;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            // acks and strobes are single-cycle pulses
            r_ld_ack  <= 1'b0;
            r_fd_ack  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_we  <= 1'b0;

            // count consecutive non-CPU grants only while the CPU is waiting
            if (!bus.cpu_req) begin
                r_starve <= '0;
            end else if (r_state == S_IDLE && w_gnt_cpu) begin
                r_starve <= '0;
            end else if (r_state == S_IDLE && (w_gnt_ld || w_gnt_fd) && r_starve != STARVE_LIM) begin
                r_starve <= r_starve + SW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_ISSUE;
                        r_busy  <= 1'b1;
                        if (w_gnt_ld) begin
                            r_owner    <= OWN_LD;
                            r_we       <= 1'b1;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= bus.ld_addr;
                            r_mem_din  <= bus.ld_din;
                        end else if (w_gnt_fd) begin
                            r_owner    <= OWN_FD;
                            r_we       <= 1'b0;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= bus.fd_addr;
                            r_mem_din  <= 8'd0;
                        end else begin
                            r_owner    <= OWN_CPU;
                            r_we       <= bus.cpu_we;
                            r_mem_we   <= bus.cpu_we;
                            r_mem_rd   <= !bus.cpu_we;
                            r_mem_addr <= bus.cpu_addr;
                            r_mem_din  <= bus.cpu_din;
                        end
                    end
                end
                S_ISSUE: begin
                    // strobe drops here; mem_ready in this cycle is not a completion
                    r_state <= S_WAIT;
                    r_tmo   <= 8'd0;
                end
                S_WAIT: begin
                    if (bus.mem_ready || r_tmo == TMO_LAST) begin
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_rd_data <= bus.mem_ready ? bus.mem_dout : 8'hFF;
                        end
                        if (!bus.mem_ready) begin
                            r_timeout_err <= 1'b1;
                        end
                        case (r_owner)
                            OWN_LD:  r_ld_ack  <= 1'b1;
                            OWN_FD:  r_fd_ack  <= 1'b1;
                            default: r_cpu_ack <= 1'b1;
                        endcase
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                default: begin
                    // DONE: ack is visible this cycle, arbitrate again next cycle
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_ack      = r_ld_ack;
    assign bus.fd_ack      = r_fd_ack;
    assign bus.cpu_ack     = r_cpu_ack;
    assign bus.cpu_wait    = bus.cpu_req && !r_cpu_ack;
    assign bus.rd_data     = r_rd_data;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_din     = r_mem_din;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_we      = r_mem_we;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests push their expected
// completions into a queue, a monitor pops one entry per ack and compares.
module tb_ram_arbiter;
    localparam int OWN_LD  = 0;
    localparam int OWN_FD  = 1;
    localparam int OWN_CPU = 2;

    typedef struct {
        int          owner;
        logic [24:0] addr;
        logic [7:0]  din;
        logic        we;
        logic [7:0]  rd;
        logic        tmo;
        int          lat;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset;

    ram_arbiter_if bus ();

    ram_arbiter #(.STARVE_MAX(2), .TIMEOUT(64)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int         n_chk  = 0;
    int         n_pass = 0;
    exp_t       exp_q[$];
    int         rsp_delay = 1;
    logic [7:0] rsp_data  = 8'h00;
    bit         rsp_early = 1'b0;
    logic [7:0] m_rd  = 8'hFF;
    logic       m_tmo = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic bit ack_of(input int who);
        case (who)
            OWN_LD:  return bus.ld_ack;
            OWN_FD:  return bus.fd_ack;
            default: return bus.cpu_ack;
        endcase
    endfunction

    task automatic push_exp(input int who, input logic [24:0] a, input logic [7:0] d,
                            input logic we, input logic [7:0] rsp, input logic tmo, input int lat);
        exp_t e;
        if (tmo) m_tmo = 1'b1;
        if (!we) m_rd = tmo ? 8'hFF : rsp;
        e.owner = who; e.addr = a; e.din = d; e.we = we;
        e.rd = m_rd; e.tmo = m_tmo; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Raise a request, hold it for n acks, then drop it in the following cycle
    task automatic do_req(input int who, input logic [24:0] a, input logic [7:0] d,
                          input logic we, input int n);
        int got = 0;
        int cyc = 0;
        bit wait_ok = 1'b1;
        @(posedge clk_sys); #1;
        case (who)
            OWN_LD:  begin bus.ld_req = 1'b1; bus.ld_addr = a; bus.ld_din = d; end
            OWN_FD:  begin bus.fd_req = 1'b1; bus.fd_addr = a; end
            default: begin bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_we = we; end
        endcase
        while (got < n && cyc < 300) begin
            @(negedge clk_sys);
            cyc++;
            if (ack_of(who)) got++;
            if (who == OWN_CPU && bus.cpu_wait !== !bus.cpu_ack) wait_ok = 1'b0;
        end
        @(posedge clk_sys); #1;
        case (who)
            OWN_LD:  bus.ld_req  = 1'b0;
            OWN_FD:  bus.fd_req  = 1'b0;
            default: bus.cpu_req = 1'b0;
        endcase
        chk("acks_received", 32'(got), 32'(n));
        if (who == OWN_CPU) chk("cpu_wait_low_only_in_ack", 32'(wait_ok), 32'd1);
    endtask

    task automatic wait_ack(input int who);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk_sys);
            seen = ack_of(who);
        end
        chk("wait_ack", 32'(seen), 32'd1);
    endtask

    // RAM model: answers a strobe after rsp_delay cycles (0 = never),
    // optionally with a bogus early pulse in the strobe cycle itself
    task automatic responder();
        int cd = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset && (bus.mem_rd || bus.mem_we)) begin
                cd = rsp_delay;
                if (rsp_early) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_dout  = ~rsp_data;
                end
            end
            @(posedge clk_sys); #1;
            bus.mem_ready = 1'b0;
            bus.mem_dout  = 8'h00;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_dout  = rsp_data;
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   cyc   = 0;
        int   s_cyc = 0;
        logic s_we  = 1'b0;
        int   own;
        int   nack;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (reset) continue;
            if (bus.mem_rd || bus.mem_we) begin
                s_cyc = cyc;
                s_we  = bus.mem_we;
                if (bus.mem_rd && bus.mem_we) chk("both_strobes", 32'd1, 32'd0);
            end
            nack = int'(bus.ld_ack) + int'(bus.fd_ack) + int'(bus.cpu_ack);
            if (nack != 0) begin
                own = (nack > 1) ? 3 : bus.ld_ack ? OWN_LD : bus.fd_ack ? OWN_FD : OWN_CPU;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack_owner", 32'(own), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", 32'(own), 32'(e.owner));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                    if (e.we) chk("mem_din", 32'(bus.mem_din), 32'(e.din));
                    chk("strobe_dir", 32'(s_we), 32'(e.we));
                    chk("rd_data", 32'(bus.rd_data), 32'(e.rd));
                    chk("timeout_err", 32'(bus.timeout_err), 32'(e.tmo));
                    chk("strobe_to_ack", 32'(cyc - s_cyc), 32'(e.lat));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_din = '0;
        bus.fd_req = 1'b0; bus.fd_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.mem_ready = 1'b0; bus.mem_dout = '0;
        fork
            responder();
            monitor();
        join_none

        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_strobes", 32'({bus.mem_rd, bus.mem_we}), 32'd0);
        chk("rst_acks", 32'({bus.ld_ack, bus.fd_ack, bus.cpu_ack}), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'hFF);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);

        // CPU read, RAM answers two cycles after the strobe
        rsp_delay = 2; rsp_data = 8'h5A;
        push_exp(OWN_CPU, 25'h000123, 8'h00, 1'b0, 8'h5A, 1'b0, 3);
        do_req(OWN_CPU, 25'h000123, 8'h00, 1'b0, 1);
        repeat (3) @(negedge clk_sys);
        chk("rd_data_held", 32'(bus.rd_data), 32'h5A);

        // single loader write at the top of the address space
        rsp_delay = 1;
        push_exp(OWN_LD, 25'h1ABCDEF, 8'hC3, 1'b1, 8'h00, 1'b0, 2);
        do_req(OWN_LD, 25'h1ABCDEF, 8'hC3, 1'b1, 1);

        // all three raised together: ld, fd, cpu, then ld again
        rsp_data = 8'h3C;
        push_exp(OWN_LD,  25'h0000010, 8'h01, 1'b1, 8'h00, 1'b0, 2);
        push_exp(OWN_FD,  25'h0000020, 8'h00, 1'b0, 8'h3C, 1'b0, 2);
        push_exp(OWN_CPU, 25'h0000030, 8'h77, 1'b1, 8'h00, 1'b0, 2);
        push_exp(OWN_LD,  25'h0000040, 8'h02, 1'b1, 8'h00, 1'b0, 2);
        fork
            begin
                do_req(OWN_LD, 25'h0000010, 8'h01, 1'b1, 1);
                wait_ack(OWN_CPU);
                do_req(OWN_LD, 25'h0000040, 8'h02, 1'b1, 1);
            end
            do_req(OWN_FD, 25'h0000020, 8'h00, 1'b0, 1);
            do_req(OWN_CPU, 25'h0000030, 8'h77, 1'b1, 1);
        join
        repeat (3) @(negedge clk_sys);
        chk("mem_addr_idle_hold", 32'(bus.mem_addr), 32'h40);

        // loader re-requesting continuously: cpu gets in after two loader grants
        rsp_data = 8'h96;
        push_exp(OWN_LD,  25'h0000050, 8'hA1, 1'b1, 8'h00, 1'b0, 2);
        push_exp(OWN_LD,  25'h0000050, 8'hA1, 1'b1, 8'h00, 1'b0, 2);
        push_exp(OWN_CPU, 25'h0000060, 8'h00, 1'b0, 8'h96, 1'b0, 2);
        push_exp(OWN_LD,  25'h0000050, 8'hA1, 1'b1, 8'h00, 1'b0, 2);
        fork
            do_req(OWN_LD, 25'h0000050, 8'hA1, 1'b1, 3);
            do_req(OWN_CPU, 25'h0000060, 8'h00, 1'b0, 1);
        join

        // bogus mem_ready during ISSUE is ignored, real one comes 3 cycles later
        rsp_delay = 3; rsp_early = 1'b1; rsp_data = 8'h22;
        push_exp(OWN_FD, 25'h00ABCDE, 8'h00, 1'b0, 8'h22, 1'b0, 4);
        do_req(OWN_FD, 25'h00ABCDE, 8'h00, 1'b0, 1);
        rsp_early = 1'b0;

        // RAM never answers: forced completion after 64 wait cycles
        rsp_delay = 0;
        push_exp(OWN_FD, 25'h00000FF, 8'h00, 1'b0, 8'h00, 1'b1, 65);
        do_req(OWN_FD, 25'h00000FF, 8'h00, 1'b0, 1);
        repeat (2) @(negedge clk_sys);
        chk("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);

        // reset while a CPU write sits in WAIT
        @(posedge clk_sys); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 25'h0000077; bus.cpu_din = 8'h55;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        chk("busy_in_wait", 32'(bus.busy), 32'd1);
        reset = 1'b1; bus.cpu_req = 1'b0;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        m_rd = 8'hFF; m_tmo = 1'b0;
        @(negedge clk_sys);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_strobes", 32'({bus.mem_rd, bus.mem_we}), 32'd0);
        chk("abort_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        chk("abort_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("abort_rd_data", 32'(bus.rd_data), 32'hFF);
        repeat (4) @(negedge clk_sys);

        rsp_delay = 1; rsp_data = 8'h4B;
        push_exp(OWN_CPU, 25'h0123456, 8'hE7, 1'b1, 8'h00, 1'b0, 2);
        do_req(OWN_CPU, 25'h0123456, 8'hE7, 1'b1, 1);
        push_exp(OWN_CPU, 25'h00000AA, 8'h00, 1'b0, 8'h4B, 1'b0, 2);
        do_req(OWN_CPU, 25'h00000AA, 8'h00, 1'b0, 1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_sys);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 2, max consecutive non-CPU grants while cpu_req is pending.
REQ-002 Parameter TIMEOUT, default 64, max WAIT cycles before forced completion (range 2..255).
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 ld_req  in  1  loader write request; level, held until ld_ack.
REQ-006 ld_addr  in  25  loader byte address.
REQ-007 ld_din  in  8  loader write data.
REQ-008 fd_req  in  1  floppy buffer read request; level, held until fd_ack.
REQ-009 fd_addr  in  25  floppy buffer byte address.
REQ-010 cpu_req  in  1  CPU access request; level, held until cpu_ack.
REQ-011 cpu_we  in  1  CPU write (1) / read (0).
REQ-012 cpu_addr  in  25  CPU byte address (already paged).
REQ-013 cpu_din  in  8  CPU write data.
REQ-014 ld_ack / fd_ack / cpu_ack  out  1 each  one-cycle completion pulse to owner.
REQ-015 rd_data  out  8  read data, valid in ack cycle, held until next read completes.
REQ-016 cpu_wait  out  1  high while cpu_req is high and no cpu_ack in that cycle.
REQ-017 mem_addr  out  25  RAM address.
REQ-018 mem_din  out  8  RAM write data.
REQ-019 mem_rd / mem_we  out  1 each  RAM strobes.
REQ-020 mem_ready  in  1  RAM completion pulse.
REQ-021 mem_dout  in  8  RAM read data, valid with mem_ready.
REQ-022 busy  out  1  high in any state other than IDLE.
REQ-023 timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Function
REQ-024 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered except cpu_wait.
REQ-025 IDLE: if any req high, select winner, latch addr/data/direction into mem_addr/mem_din, go ISSUE; else stay.
REQ-026 Priority ld > fd > cpu, except cpu wins when cpu_req high and starve counter equals STARVE_MAX.
REQ-027 Starve counter: +1 on each ld/fd grant while cpu_req high; cleared on cpu grant or whenever cpu_req low; saturates at STARVE_MAX.
REQ-028 Loader grant is always a write; floppy grant always a read; CPU direction from cpu_we.
REQ-029 ISSUE: exactly one of mem_rd/mem_we high for one cycle; go WAIT.
REQ-030 WAIT: on mem_ready latch mem_dout into rd_data (reads only), go DONE; mem_ready outside WAIT ignored.
REQ-031 WAIT timeout: after TIMEOUT cycles without mem_ready, rd_data = 0xFF (reads only), set timeout_err, go DONE.
REQ-032 DONE: owner ack high one cycle, go IDLE; new arbitration no earlier than next IDLE cycle.
REQ-033 Minimum latency: req sampled in IDLE cycle N, mem strobe N+1, mem_ready at N+2 earliest, ack N+3.
REQ-034 mem_addr/mem_din stable from ISSUE through DONE; unchanged in IDLE with no grant.
REQ-035 Owner dropping req mid-transaction: transaction completes, ack still pulsed.
REQ-036 Requester must drop req the cycle after ack; a req still high in the following IDLE is a new request.

Reset
REQ-037 On reset: state IDLE, all acks 0, mem_rd/mem_we 0, busy 0, rd_data 0xFF, mem_addr 0, mem_din 0, starve counter 0, timeout_err 0.
REQ-038 Reset mid-transaction aborts it: no ack issued, strobes low from the next edge.

Verification
REQ-039 cpu_req read 0x000123, mem_ready 2 cycles after mem_rd with 0x5A -> cpu_ack at N+4, rd_data 0x5A, cpu_wait low only in ack cycle.
REQ-040 ld_req, fd_req, cpu_req raised same cycle, held, STARVE_MAX=2 -> grant order ld, fd, cpu, then ld.
REQ-041 ld_req held continuously re-requesting plus cpu_req -> cpu granted after exactly 2 loader grants.
REQ-042 fd read with mem_ready never asserted, TIMEOUT=64 -> fd_ack 65 cycles after mem_rd, rd_data 0xFF, timeout_err 1.
REQ-043 reset in WAIT of cpu write -> no cpu_ack, busy 0 next cycle, following cpu_req served normally.
REQ-044 mem_ready pulsed in ISSUE cycle -> ignored; completion only on later mem_ready in WAIT.
